// File: rtl/updown_counter_p.sv
// Prescaled up/down counter with bounded, free-run, bounce and hold modes.
// Adds clear, load, terminal-count pulse, limit/direction status and an LED bus.
module updown_counter_p #(
  parameter int unsigned WIDTH   = 24,
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned LED_W   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic               updown,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] divideby,
  output logic [WIDTH-1:0]   count,
  output logic               tc,
  output logic               at_limit,
  output logic               dir_out,
  output logic               divide_err,
  output logic [LED_W-1:0]   led
);

  typedef enum logic [1:0] {
    ModeBounded = 2'b00,
    ModeFree    = 2'b01,
    ModeBounce  = 2'b10,
    ModeHold    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]   CntOne = WIDTH'(1);
  localparam logic [PRESC_W-1:0] PreOne = PRESC_W'(1);

  mode_e              mode_sel;
  logic [PRESC_W-1:0] pre_cnt, pre_d;
  logic [WIDTH-1:0]   count_d, count_inc, count_dec;
  logic               dir_d, tc_d, tick;

  assign mode_sel   = mode_e'(mode);
  assign count_inc  = count + CntOne;
  assign count_dec  = count - CntOne;
  assign divide_err = (divideby == '0);
  // >= rather than == so lowering divideby mid-period still ends the period.
  assign tick       = enable && (pre_cnt >= (divideby - PreOne));
  assign at_limit   = (count == limit);
  assign led        = divide_err ? '1 : count[WIDTH-1 -: LED_W];

  always_comb begin
    count_d = count;
    pre_d   = pre_cnt;
    dir_d   = dir_out;
    tc_d    = 1'b0;
    if (clear) begin
      count_d = '0;
      pre_d   = '0;
      dir_d   = 1'b1;
    end else if (load) begin
      count_d = load_val;
      pre_d   = '0;
    end else begin
      if (mode_sel != ModeBounce) dir_d = updown;
      if (!divide_err && enable) begin
        pre_d = tick ? '0 : pre_cnt + PreOne;
        if (tick) begin
          unique case (mode_sel)
            ModeBounded: begin
              if (updown && (count < limit)) begin
                count_d = count_inc;
                tc_d    = (count_inc == limit);
              end else if (!updown && (count > limit)) begin
                count_d = count_dec;
                tc_d    = (count_dec == limit);
              end
            end
            ModeFree: begin
              if (updown) begin
                count_d = count_inc;
                tc_d    = (count == '1);
              end else begin
                count_d = count_dec;
                tc_d    = (count == '0);
              end
            end
            ModeBounce: begin
              // Bounce steers by the registered direction, not updown.
              if (dir_out) begin
                if (count < limit) begin
                  count_d = count_inc;
                  if (count_inc == limit) begin
                    dir_d = 1'b0;
                    tc_d  = 1'b1;
                  end
                end else begin
                  dir_d = 1'b0;
                end
              end else begin
                if (count > '0) begin
                  count_d = count_dec;
                  if (count_dec == '0) begin
                    dir_d = 1'b1;
                    tc_d  = 1'b1;
                  end
                end else begin
                  dir_d = 1'b1;
                end
              end
            end
            ModeHold: begin
              count_d = count;
            end
            default: begin
              count_d = count;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
      dir_out <= 1'b1;
    end else begin
      count   <= count_d;
      pre_cnt <= pre_d;
      tc      <= tc_d;
      dir_out <= dir_d;
    end
  end

endmodule

// File: tb/tb_updown_counter_p.sv
// Scoreboard bench for updown_counter_p: stimulus pushes model predictions,
// a monitor compares them against the DUT after every rising edge.
module tb_updown_counter_p;

  localparam int unsigned WIDTH   = 24;
  localparam int unsigned PRESC_W = 6;
  localparam int unsigned LED_W   = 10;
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 1;
  localparam longint unsigned LEDMAX = (64'd1 << LED_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable, clear, load, updown;
  logic [WIDTH-1:0]   load_val, limit;
  logic [1:0]         mode;
  logic [PRESC_W-1:0] divideby;
  logic [WIDTH-1:0]   count;
  logic               tc, at_limit, dir_out, divide_err;
  logic [LED_W-1:0]   led;

  updown_counter_p #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W),
    .LED_W  (LED_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .updown    (updown),
    .mode      (mode),
    .limit     (limit),
    .divideby  (divideby),
    .count     (count),
    .tc        (tc),
    .at_limit  (at_limit),
    .dir_out   (dir_out),
    .divide_err(divide_err),
    .led       (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned count;
    bit              tc;
    bit              dir;
    bit              at_limit;
    bit              derr;
    longint unsigned led;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  longint unsigned m_count;
  int unsigned     m_pre;
  bit              m_dir;
  bit              m_tc;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pre   = 0;
    m_dir   = 1'b1;
    m_tc    = 1'b0;
  endtask

  // One clock edge of behaviour, from the current inputs.
  task automatic model_step();
    longint unsigned lim = limit;
    bit old_dir = m_dir;
    bit tick;
    m_tc = 1'b0;
    if (clear) begin
      m_count = 0; m_pre = 0; m_dir = 1'b1;
    end else if (load) begin
      m_count = load_val; m_pre = 0;
    end else begin
      if (mode != 2'b10) m_dir = updown;
      if (divideby != 0 && enable) begin
        tick = (m_pre + 1 >= divideby);
        m_pre = tick ? 0 : m_pre + 1;
        if (tick) begin
          case (mode)
            2'b00: begin
              if (updown && m_count < lim) begin
                m_count++; m_tc = (m_count == lim);
              end else if (!updown && m_count > lim) begin
                m_count--; m_tc = (m_count == lim);
              end
            end
            2'b01: begin
              if (updown) begin
                m_tc = (m_count == MAXV); m_count = (m_count + 1) % (MAXV + 1);
              end else begin
                m_tc = (m_count == 0); m_count = (m_count + MAXV) % (MAXV + 1);
              end
            end
            2'b10: begin
              if (old_dir) begin
                if (m_count < lim) begin
                  m_count++;
                  if (m_count == lim) begin m_dir = 1'b0; m_tc = 1'b1; end
                end else m_dir = 1'b0;
              end else begin
                if (m_count > 0) begin
                  m_count--;
                  if (m_count == 0) begin m_dir = 1'b1; m_tc = 1'b1; end
                end else m_dir = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic drive(input bit en, input bit clr, input bit ld, input longint unsigned lv,
                       input bit ud, input int unsigned md, input longint unsigned lim,
                       input int unsigned div);
    exp_t e;
    @(negedge clk);
    enable = en; clear = clr; load = ld; load_val = WIDTH'(lv); updown = ud;
    mode = 2'(md); limit = WIDTH'(lim); divideby = PRESC_W'(div);
    model_step();
    e.count    = m_count;
    e.tc       = m_tc;
    e.dir      = m_dir;
    e.at_limit = (m_count == lim);
    e.derr     = (div == 0);
    e.led      = e.derr ? LEDMAX : (m_count >> (WIDTH - LED_W));
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a new result after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count", count, e.count);
        chk("tc", tc, e.tc);
        chk("dir_out", dir_out, e.dir);
        chk("at_limit", at_limit, e.at_limit);
        chk("divide_err", divide_err, e.derr);
        chk("led", led, e.led);
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 0; clear = 0; load = 0; load_val = '0; updown = 1;
    mode = 2'b00; limit = '0; divideby = PRESC_W'(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_tc", tc, 0);
    chk("reset_dir", dir_out, 1);
    @(negedge clk);
    #1 reset = 1'b0;

    // Bounded up to 3
    repeat (5) drive(1, 0, 0, 0, 1, 0, 3, 1);
    // Bounded down toward a limit above the count never moves; then down to 1
    drive(1, 0, 0, 0, 0, 0, 8, 1);
    repeat (3) drive(1, 0, 0, 0, 0, 0, 1, 1);

    // Free-run wrap with prescale 4, pre_cnt holding while disabled
    drive(0, 0, 1, 'hFFFFFE, 1, 1, 0, 4);
    drive(1, 0, 0, 0, 1, 1, 0, 4);
    repeat (3) drive(0, 0, 0, 0, 1, 1, 0, 4);
    repeat (8) drive(1, 0, 0, 0, 1, 1, 0, 4);
    // Free-run down wraps from 0
    drive(0, 0, 1, 0, 0, 1, 0, 1);
    repeat (2) drive(1, 0, 0, 0, 0, 1, 0, 1);

    // Bounce between 0 and 2, then limit 0
    drive(0, 1, 0, 0, 0, 2, 2, 1);
    repeat (6) drive(1, 0, 0, 0, 0, 2, 2, 1);
    drive(0, 1, 0, 0, 0, 2, 0, 1);
    repeat (3) drive(1, 0, 0, 0, 1, 2, 0, 1);

    // Divide error freezes count, load still acts
    drive(0, 0, 1, 'h123456, 1, 1, 0, 1);
    repeat (3) drive(1, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 1, 'h10, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 1, 1, 0, 0);

    // Priority: clear beats load; load beats divide error
    drive(0, 0, 1, 7, 1, 3, 0, 1);
    drive(1, 1, 1, 'h55, 1, 3, 0, 1);
    drive(1, 0, 1, 'h99, 1, 3, 0, 0);
    // Hold mode keeps count with ticks running
    repeat (3) drive(1, 0, 0, 0, 0, 3, 0, 2);

    // Asynchronous reset between edges with count at 5
    drive(0, 1, 0, 0, 1, 0, 10, 1);
    repeat (5) drive(1, 0, 0, 0, 1, 0, 10, 1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_count", count, 0);
    chk("async_tc", tc, 0);
    chk("async_dir", dir_out, 1);
    reset = 1'b0;
    model_reset();
    repeat (3) drive(1, 0, 0, 0, 1, 0, 10, 2);

    // Randomised traffic
    begin
      longint unsigned lim = 5;
      int unsigned md = 0;
      for (int i = 0; i < 600; i++) begin
        int unsigned r = $urandom_range(0, 99);
        int unsigned dv = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 3);
        longint unsigned lv = $urandom_range(0, 1) ? longint'($urandom_range(0, 20))
                                                  : MAXV - $urandom_range(0, 3);
        if (i % 32 == 0) begin
          lim = $urandom_range(0, 15);
          md  = $urandom_range(0, 3);
        end
        drive($urandom_range(0, 9) < 8, r < 2, r >= 2 && r < 7, lv, 1'($urandom_range(0, 1)),
              md, lim, dv);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
